// File: rtl/mc_ctrl_fsm.sv
// Main sequencing FSM for the multi-cycle MIPS core: drives datapath selects and
// enables, handshakes with memory, flags illegal opcodes and counts retirements.
module mc_ctrl_fsm #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [5:0]       opcode,
    input  logic             halt,
    input  logic             mem_ready,
    output logic             mem_req,
    output logic             mem_we,
    output logic             iord,
    output logic             ir_write,
    output logic             pc_write,
    output logic             branch,
    output logic [1:0]       pc_src,
    output logic             alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [1:0]       alu_op,
    output logic             reg_dst,
    output logic             mem_to_reg,
    output logic             reg_write,
    output logic             retire,
    output logic             illegal_op,
    output logic [CNT_W-1:0] instret,
    output logic [3:0]       state
);

    typedef enum logic [3:0] {
        S_IDLE   = 4'd0,
        S_FETCH  = 4'd1,
        S_DECODE = 4'd2,
        S_MEMADR = 4'd3,
        S_MEMRD  = 4'd4,
        S_MEMWB  = 4'd5,
        S_MEMWR  = 4'd6,
        S_EXEC   = 4'd7,
        S_ALUWB  = 4'd8,
        S_BRANCH = 4'd9,
        S_ADDIEX = 4'd10,
        S_ADDIWB = 4'd11,
        S_JUMP   = 4'd12
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    state_t             r_state;
    state_t             w_next;
    state_t             w_boundary;
    logic               r_illegal;
    logic [CNT_W-1:0]   r_instret;
    logic               w_set_illegal;

    // halt is sampled only where an instruction ends
    assign w_boundary = halt ? S_IDLE : S_FETCH;

    always_comb begin
        w_next        = r_state;
        w_set_illegal = 1'b0;
        mem_req       = 1'b0;
        mem_we        = 1'b0;
        iord          = 1'b0;
        ir_write      = 1'b0;
        pc_write      = 1'b0;
        branch        = 1'b0;
        pc_src        = 2'b00;
        alu_src_a     = 1'b0;
        alu_src_b     = 2'b00;
        alu_op        = 2'b00;
        reg_dst       = 1'b0;
        mem_to_reg    = 1'b0;
        reg_write     = 1'b0;
        retire        = 1'b0;
        case (r_state)
            S_IDLE: w_next = w_boundary;
            S_FETCH: begin
                mem_req   = 1'b1;
                alu_src_b = 2'b01;
                if (mem_ready) begin
                    ir_write = 1'b1;
                    pc_write = 1'b1;
                    w_next   = S_DECODE;
                end
            end
            S_DECODE: begin
                alu_src_b = 2'b11;
                case (opcode)
                    OP_LW, OP_SW: w_next = S_MEMADR;
                    OP_RTYPE:     w_next = S_EXEC;
                    OP_BEQ:       w_next = S_BRANCH;
                    OP_ADDI:      w_next = S_ADDIEX;
                    OP_J:         w_next = S_JUMP;
                    default: begin
                        w_set_illegal = 1'b1;
                        w_next        = w_boundary;
                    end
                endcase
            end
            S_MEMADR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                w_next    = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
            end
            S_MEMRD: begin
                mem_req = 1'b1;
                iord    = 1'b1;
                if (mem_ready) w_next = S_MEMWB;
            end
            S_MEMWB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
                retire     = 1'b1;
                w_next     = w_boundary;
            end
            S_MEMWR: begin
                mem_req = 1'b1;
                mem_we  = 1'b1;
                iord    = 1'b1;
                if (mem_ready) begin
                    retire = 1'b1;
                    w_next = w_boundary;
                end
            end
            S_EXEC: begin
                alu_src_a = 1'b1;
                alu_op    = 2'b10;
                w_next    = S_ALUWB;
            end
            S_ALUWB: begin
                reg_write = 1'b1;
                reg_dst   = 1'b1;
                retire    = 1'b1;
                w_next    = w_boundary;
            end
            S_BRANCH: begin
                alu_src_a = 1'b1;
                alu_op    = 2'b01;
                branch    = 1'b1;
                pc_src    = 2'b01;
                retire    = 1'b1;
                w_next    = w_boundary;
            end
            S_ADDIEX: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                w_next    = S_ADDIWB;
            end
            S_ADDIWB: begin
                reg_write = 1'b1;
                retire    = 1'b1;
                w_next    = w_boundary;
            end
            S_JUMP: begin
                pc_write = 1'b1;
                pc_src   = 2'b10;
                retire   = 1'b1;
                w_next   = w_boundary;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_illegal <= 1'b0;
            r_instret <= '0;
        end else begin
            r_state <= w_next;
            if (w_set_illegal) r_illegal <= 1'b1;
            if (retire)        r_instret <= r_instret + CNT_W'(1);
        end
    end

    assign illegal_op = r_illegal;
    assign instret    = r_instret;
    assign state      = r_state;

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// Bench for mc_ctrl_fsm: instruction-level model expands each instruction into
// its per-cycle stimulus and expected outputs; one loop drives and compares.
module tb_mc_ctrl_fsm;

    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [5:0]    opcode = 6'd0;
    logic          halt = 1'b0;
    logic          mem_ready = 1'b0;
    logic          mem_req, mem_we, iord, ir_write, pc_write, branch;
    logic [1:0]    pc_src, alu_src_b, alu_op;
    logic          alu_src_a, reg_dst, mem_to_reg, reg_write, retire, illegal_op;
    logic [CW-1:0] instret;
    logic [3:0]    state;

    mc_ctrl_fsm #(.CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .halt(halt), .mem_ready(mem_ready),
        .mem_req(mem_req), .mem_we(mem_we), .iord(iord), .ir_write(ir_write),
        .pc_write(pc_write), .branch(branch), .pc_src(pc_src), .alu_src_a(alu_src_a),
        .alu_src_b(alu_src_b), .alu_op(alu_op), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
        .reg_write(reg_write), .retire(retire), .illegal_op(illegal_op),
        .instret(instret), .state(state)
    );

    always #5 clk = ~clk;

    localparam logic [5:0] OP_R = 6'b000000, OP_LW = 6'b100011, OP_SW = 6'b101011;
    localparam logic [5:0] OP_BEQ = 6'b000100, OP_ADDI = 6'b001000, OP_J = 6'b000010;
    localparam logic [5:0] OP_BAD = 6'b111111;

    // Control bundle: mem_req mem_we iord ir_write pc_write branch pc_src alu_src_a
    //                 alu_src_b alu_op reg_dst mem_to_reg reg_write retire
    function automatic logic [16:0] cv(input logic mrq, mwe, io, irw, pcw, br,
                                       input logic [1:0] pcs, input logic asa,
                                       input logic [1:0] asb, aop,
                                       input logic rd, m2r, rw, ret);
        return {mrq, mwe, io, irw, pcw, br, pcs, asa, asb, aop, rd, m2r, rw, ret};
    endfunction

    wire [16:0] act_ctl = {mem_req, mem_we, iord, ir_write, pc_write, branch, pc_src,
                           alu_src_a, alu_src_b, alu_op, reg_dst, mem_to_reg, reg_write, retire};

    typedef struct {
        logic          rstn, h, rdy, chk;
        logic [5:0]    op;
        logic [3:0]    st;
        logic [16:0]   ctl;
        logic [CW-1:0] inst;
        logic          ill;
        int            pin;
    } rec_t;

    rec_t          q[$];
    logic [CW-1:0] m_inst = '0;
    logic          m_ill = 1'b0;
    int            m_pin = -1;
    int            nchk = 0;
    int            nerr = 0;

    task automatic push(input logic [3:0] st, input logic [16:0] ctl, input logic [5:0] op,
                        input logic rdy, input logic h, input logic rstn);
        rec_t r;
        r.rstn = rstn; r.h = h; r.rdy = rdy; r.chk = 1'b1; r.op = op; r.st = st;
        r.ctl = ctl; r.inst = m_inst; r.ill = m_ill; r.pin = m_pin;
        m_pin = -1;
        q.push_back(r);
        if (!rstn) begin
            m_inst = '0;
            m_ill  = 1'b0;
        end else if (ctl[0]) begin
            m_inst = m_inst + 1'b1;
        end
    endtask

    task automatic idle(input int n, input logic h);
        for (int k = 0; k < n; k++) push(4'd0, 17'd0, OP_R, 1'b1, h, 1'b1);
    endtask

    task automatic fetch(input logic [5:0] op, input int fw);
        for (int k = 0; k < fw; k++)
            push(4'd1, cv(1,0,0,0,0,0,2'b00,0,2'b01,2'b00,0,0,0,0), op, 1'b0, 1'b0, 1'b1);
        push(4'd1, cv(1,0,0,1,1,0,2'b00,0,2'b01,2'b00,0,0,0,0), op, 1'b1, 1'b0, 1'b1);
    endtask

    // One complete instruction; halt (h) is driven from after DECODE onward.
    task automatic ins(input logic [5:0] op, input int fw, input int mw, input logic h);
        logic legal;
        legal = (op inside {OP_R, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J});
        fetch(op, fw);
        push(4'd2, cv(0,0,0,0,0,0,2'b00,0,2'b11,2'b00,0,0,0,0), op, 1'b1, legal ? 1'b0 : h, 1'b1);
        case (op)
            OP_LW: begin
                push(4'd3, cv(0,0,0,0,0,0,2'b00,1,2'b10,2'b00,0,0,0,0), op, 1'b1, h, 1'b1);
                for (int k = 0; k < mw; k++)
                    push(4'd4, cv(1,0,1,0,0,0,2'b00,0,2'b00,2'b00,0,0,0,0), op, 1'b0, h, 1'b1);
                push(4'd4, cv(1,0,1,0,0,0,2'b00,0,2'b00,2'b00,0,0,0,0), op, 1'b1, h, 1'b1);
                push(4'd5, cv(0,0,0,0,0,0,2'b00,0,2'b00,2'b00,0,1,1,1), op, 1'b1, h, 1'b1);
            end
            OP_SW: begin
                push(4'd3, cv(0,0,0,0,0,0,2'b00,1,2'b10,2'b00,0,0,0,0), op, 1'b1, h, 1'b1);
                for (int k = 0; k < mw; k++)
                    push(4'd6, cv(1,1,1,0,0,0,2'b00,0,2'b00,2'b00,0,0,0,0), op, 1'b0, h, 1'b1);
                push(4'd6, cv(1,1,1,0,0,0,2'b00,0,2'b00,2'b00,0,0,0,1), op, 1'b1, h, 1'b1);
            end
            OP_R: begin
                push(4'd7, cv(0,0,0,0,0,0,2'b00,1,2'b00,2'b10,0,0,0,0), op, 1'b1, h, 1'b1);
                push(4'd8, cv(0,0,0,0,0,0,2'b00,0,2'b00,2'b00,1,0,1,1), op, 1'b1, h, 1'b1);
            end
            OP_BEQ:
                push(4'd9, cv(0,0,0,0,0,1,2'b01,1,2'b00,2'b01,0,0,0,1), op, 1'b1, h, 1'b1);
            OP_ADDI: begin
                push(4'd10, cv(0,0,0,0,0,0,2'b00,1,2'b10,2'b00,0,0,0,0), op, 1'b1, h, 1'b1);
                push(4'd11, cv(0,0,0,0,0,0,2'b00,0,2'b00,2'b00,0,0,1,1), op, 1'b1, h, 1'b1);
            end
            OP_J:
                push(4'd12, cv(0,0,0,0,1,0,2'b10,0,2'b00,2'b00,0,0,0,1), op, 1'b1, h, 1'b1);
            default: m_ill = 1'b1;
        endcase
    endtask

    task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s rec=%0d got=%0h expected=%0h", nm, idx, act, exp);
        end
    endtask

    initial begin
        // power-on reset cycle (outputs undefined until it lands)
        push(4'd0, 17'd0, OP_R, 1'b0, 1'b0, 1'b0);
        q[0].chk = 1'b0;
        idle(1, 1'b0);
        for (int k = 0; k < 3; k++) ins(OP_R, 0, 0, 1'b0);
        m_pin = 3;
        ins(OP_LW, 3, 2, 1'b0);
        m_pin = 4;
        // reset while lw is waiting in MEMRD with mem_req high
        fetch(OP_LW, 0);
        push(4'd2, cv(0,0,0,0,0,0,2'b00,0,2'b11,2'b00,0,0,0,0), OP_LW, 1'b1, 1'b0, 1'b1);
        push(4'd3, cv(0,0,0,0,0,0,2'b00,1,2'b10,2'b00,0,0,0,0), OP_LW, 1'b1, 1'b0, 1'b1);
        push(4'd4, cv(1,0,1,0,0,0,2'b00,0,2'b00,2'b00,0,0,0,0), OP_LW, 1'b0, 1'b0, 1'b1);
        push(4'd4, cv(1,0,1,0,0,0,2'b00,0,2'b00,2'b00,0,0,0,0), OP_LW, 1'b0, 1'b0, 1'b0);
        m_pin = 0;
        idle(1, 1'b0);
        ins(OP_SW, 0, 1, 1'b0);
        ins(OP_BEQ, 0, 0, 1'b0);
        ins(OP_J, 0, 0, 1'b0);
        ins(OP_ADDI, 1, 0, 1'b0);
        m_pin = 4;
        ins(OP_BAD, 0, 0, 1'b0);
        m_pin = 4;
        ins(OP_R, 0, 0, 1'b1);
        idle(2, 1'b1);
        m_pin = 5;
        idle(1, 1'b0);
        for (int k = 0; k < 10; k++) ins(OP_R, 0, 0, 1'b0);
        m_pin = 15;
        ins(OP_R, 0, 0, 1'b1);
        m_pin = 0;
        idle(1, 1'b1);

        foreach (q[i]) begin
            @(negedge clk);
            rst_n     = q[i].rstn;
            halt      = q[i].h;
            mem_ready = q[i].rdy;
            opcode    = q[i].op;
            #1;
            if (q[i].chk) begin
                chk("state", i, 32'(state), 32'(q[i].st));
                chk("controls", i, 32'(act_ctl), 32'(q[i].ctl));
                chk("instret", i, 32'(instret), 32'(q[i].inst));
                chk("illegal_op", i, 32'(illegal_op), 32'(q[i].ill));
                if (q[i].pin >= 0) chk("instret_literal", i, 32'(instret), 32'(q[i].pin));
            end
        end
        // literal pins on the sticky flag, independent of the model
        chk("illegal_sticky_end", 0, 32'(illegal_op), 32'd1);
        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule

// File: doc/mc_ctrl_fsm.md
Name: mc_ctrl_fsm

Overview:
Main control state machine for the multi-cycle MIPS core. It sequences the shared PC/ALU/memory datapath over FETCH, DECODE, EXECUTE, MEMORY and WRITEBACK steps. It drives all datapath mux selects and write enables, and waits on a memory ready handshake. It also reports illegal opcodes and keeps a retired-instruction counter.

Parameters:
CNT_W, 32, width of the retired-instruction counter instret

Ports:
clk  in  1  system clock
rst_n  in  1  reset, synchronous, active-low
opcode  in  6  instr[31:26] from the instruction register
halt  in  1  hold the core in IDLE at the next instruction boundary
mem_ready  in  1  memory access complete this cycle
mem_req  out  1  memory access request
mem_we  out  1  memory write (valid with mem_req)
iord  out  1  memory address select: 0 = PC, 1 = ALUOut
ir_write  out  1  load instruction register
pc_write  out  1  unconditional PC load
branch  out  1  PC load if ALU zero
pc_src  out  2  next-PC select: 00 = ALU result, 01 = ALUOut, 10 = jump target
alu_src_a  out  1  ALU A select: 0 = PC, 1 = rs
alu_src_b  out  2  ALU B select: 00 = rt, 01 = 4, 10 = SignImm, 11 = SignImm<<2
alu_op  out  2  ALU operation: 00 = add, 01 = sub, 10 = funct-decoded
reg_dst  out  1  write register select: 0 = rt, 1 = rd
mem_to_reg  out  1  write data select: 0 = ALUOut, 1 = memory data
reg_write  out  1  register file write enable
retire  out  1  one-cycle pulse when an instruction completes
illegal_op  out  1  sticky: an unsupported opcode was decoded
instret  out  CNT_W  count of retired instructions, wraps modulo 2^CNT_W
state  out  4  current state encoding (debug and verification)

Behaviour:
- State encodings: IDLE=0, FETCH=1, DECODE=2, MEMADR=3, MEMRD=4, MEMWB=5, MEMWR=6, EXEC=7, ALUWB=8, BRANCH=9, ADDIEX=10, ADDIWB=11, JUMP=12. Encodings 13-15 are unreachable; if entered, go to IDLE.
- Reset (rst_n=0 at a clk edge): state=IDLE, illegal_op=0, instr_retired counter instret=0. Reset overrides everything, including mid-access or mid-instruction. No memory transaction resumes after reset.
- Every control output not listed for a state is 0.
- Control outputs are decoded from state. ir_write, pc_write and retire in the memory states also depend on mem_ready.
- IDLE: all control outputs 0. Next state is FETCH if halt=0, else stay in IDLE.
- FETCH: mem_req=1, iord=0, alu_src_a=0, alu_src_b=01, alu_op=00, pc_src=00.
  - If mem_ready=1: ir_write=1, pc_write=1 (PC <= PC+4), next DECODE.
  - If mem_ready=0: ir_write=0, pc_write=0, stay in FETCH.
- DECODE: alu_src_a=0, alu_src_b=11, alu_op=00 (computes the branch target). Next state by opcode:
  - 100011 (lw) or 101011 (sw): MEMADR
  - 000000 (R-type): EXEC
  - 000100 (beq): BRANCH
  - 001000 (addi): ADDIEX
  - 000010 (j): JUMP
  - any other opcode: set illegal_op, return to FETCH or IDLE per the boundary rule. No retire; the instruction is skipped.
- MEMADR: alu_src_a=1, alu_src_b=10, alu_op=00. Next MEMRD for lw, MEMWR for sw.
- MEMRD: mem_req=1, iord=1. Wait for mem_ready, then go to MEMWB.
- MEMWB: reg_write=1, mem_to_reg=1, reg_dst=0, retire=1.
- MEMWR: mem_req=1, mem_we=1, iord=1. Wait for mem_ready; in the mem_ready cycle retire=1 and the instruction completes.
- EXEC: alu_src_a=1, alu_src_b=00, alu_op=10. Next ALUWB.
- ALUWB: reg_write=1, reg_dst=1, mem_to_reg=0, retire=1.
- BRANCH: alu_src_a=1, alu_src_b=00, alu_op=01, branch=1, pc_src=01, retire=1.
- ADDIEX: alu_src_a=1, alu_src_b=10, alu_op=00. Next ADDIWB.
- ADDIWB: reg_write=1, reg_dst=0, mem_to_reg=0, retire=1.
- JUMP: pc_write=1, pc_src=10, retire=1.
- Instruction boundary: leaving MEMWB, MEMWR (with mem_ready), ALUWB, BRANCH, ADDIWB, JUMP, or DECODE on an illegal opcode.
  - halt=1 at the boundary: next IDLE.
  - halt=0: next FETCH.
  - halt is never checked mid-instruction.
- Instruction latency with mem_ready=1 every cycle:
  - lw: 5 cycles
  - sw, R-type, addi: 4 cycles
  - beq, j: 3 cycles
  - Each memory wait cycle adds 1.
- mem_req stays held high with constant iord and mem_we until mem_ready. mem_ready outside FETCH/MEMRD/MEMWR is ignored.
- instret increments by 1 in the same cycle retire=1 (new value visible the next cycle) and wraps from all-ones to 0.
- illegal_op stays set until reset; execution continues.

Test Plan:
- Reset mid-MEMRD with mem_req=1 -> next cycle state=0, mem_req=0, instret=0, illegal_op=0; with halt=0, FETCH follows.
- R-type stream (opcode 000000), mem_ready tied 1, halt=0 -> state sequence 1,2,7,8 repeating; retire pulses every 4 cycles; instret=3 after 12 cycles from FETCH.
- lw with mem_ready low 3 cycles in FETCH and 2 in MEMRD -> 10 cycles FETCH to retire; ir_write and pc_write high only in the single FETCH mem_ready cycle; mem_req/iord held constant while waiting.
- sw, beq, j and addi in sequence -> sw: mem_we=1 in MEMWR; beq: branch=1, pc_src=01, alu_op=01; j: pc_write=1, pc_src=10; addi: reg_write with reg_dst=0; instret=4.
- Opcode 111111 -> DECODE returns to FETCH, illegal_op=1 and stays 1, no retire, instret unchanged.
- halt raised during EXEC -> ALUWB completes (retire=1), then IDLE with all controls 0; halt dropped -> FETCH next cycle.
- instret preloaded near all-ones with CNT_W=4 -> after 15, next retire gives 0.
